// File: rtl/mmio_fifo_ctrl.sv
// mmio_fifo_ctrl: MMIO-mapped FIFO controller with external RAM and 2-stage ordered read responses.
// Optional MMIO_FIFO_STATS_EN adds 32-bit push/pop counters readable at BASE+6.
module mmio_fifo_ctrl #(
  parameter int          DEPTH_LOG2 = 3,
  parameter int          DATA_W     = 64,
  parameter logic [15:0] BASE_ADDR  = 16'h0020
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mmio_wr_valid,
  input  logic                  mmio_rd_valid,
  input  logic [15:0]           mmio_addr,
  input  logic [8:0]            mmio_tid,
  input  logic [63:0]           mmio_wdata,
  output logic                  resp_valid,
  output logic [8:0]            resp_tid,
  output logic [63:0]           resp_data,
  output logic                  hit,
  output logic                  ram_we,
  output logic [DEPTH_LOG2-1:0] ram_waddr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DEPTH_LOG2-1:0] ram_raddr,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [DEPTH_LOG2:0]   count
);
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  ovf, udf, empty, full;
  logic                  in_win, is_data, is_status, is_ctrl, is_stats;
  logic                  push_try, pop_try, push, pop, clr_ptr, clr_flag;
  logic [63:0]           status_word, stats_word, snap;
  logic                  s1_valid, s1_pop;
  logic [8:0]            s1_tid;
  logic [63:0]           s1_snap;
  assign in_win    = (mmio_addr >= BASE_ADDR) && (mmio_addr < BASE_ADDR + 16'd8);
  assign is_data   = mmio_addr == BASE_ADDR;
  assign is_status = mmio_addr == BASE_ADDR + 16'd2;
  assign is_ctrl   = mmio_addr == BASE_ADDR + 16'd4;
  assign is_stats  = mmio_addr == BASE_ADDR + 16'd6;
  assign empty     = count == '0;
  // occupancy never exceeds the depth, so its MSB alone marks full
  assign full      = count[DEPTH_LOG2];
  assign hit       = mmio_rd_valid && in_win;
  assign push_try  = mmio_wr_valid && is_data;
  assign pop_try   = mmio_rd_valid && is_data;
  assign push      = push_try && !full;
  assign pop       = pop_try && !empty;
  assign clr_ptr   = mmio_wr_valid && is_ctrl && mmio_wdata[0];
  assign clr_flag  = mmio_wr_valid && is_ctrl && mmio_wdata[1];
  assign ram_we    = push && !clr_ptr && rst_n;
  assign ram_waddr = wr_ptr;
  assign ram_wdata = mmio_wdata[DATA_W-1:0];
  assign ram_raddr = rd_ptr;
  assign status_word = {44'd0, udf, ovf, full, empty, {(15-DEPTH_LOG2){1'b0}}, count};
  assign snap = is_status ? status_word : is_stats ? stats_word : 64'd0;
`ifdef MMIO_FIFO_STATS_EN
  logic [31:0] push_cnt, pop_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
    end else if (clr_flag) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
    end else begin
      push_cnt <= push_cnt + {31'd0, push && !clr_ptr};
      pop_cnt  <= pop_cnt + {31'd0, pop};
    end
  end
  assign stats_word = {pop_cnt, push_cnt};
`else
  assign stats_word = 64'd0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr_ptr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (clr_flag) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf || (push_try && full);
      udf <= udf || (pop_try && empty);
    end
  end
  // stage 1 holds the request while RAM data arrives; stage 2 is the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_pop     <= 1'b0;
      s1_tid     <= '0;
      s1_snap    <= '0;
      resp_valid <= 1'b0;
      resp_tid   <= '0;
      resp_data  <= '0;
    end else begin
      s1_valid   <= hit;
      s1_pop     <= pop;
      s1_tid     <= mmio_tid;
      s1_snap    <= snap;
      resp_valid <= s1_valid;
      resp_tid   <= s1_tid;
      resp_data  <= s1_pop ? 64'(ram_rdata) : s1_snap;
    end
  end
endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// tb_mmio_fifo_ctrl: table-driven directed checks of mmio_fifo_ctrl with a behavioural RAM.
module tb_mmio_fifo_ctrl;
  localparam logic [15:0] BASE = 16'h0020;
  localparam logic [15:0] STAT = 16'h0022;
  localparam logic [15:0] CTRL = 16'h0024;
  localparam logic [15:0] STS  = 16'h0026;
`ifdef MMIO_FIFO_STATS_EN
  localparam logic [63:0] STATS_EXP = 64'h0000_0002_0000_0003;
`else
  localparam logic [63:0] STATS_EXP = 64'h0;
`endif
  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [8:0]  tid;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic [3:0]  exp_count;
  } vec_t;
  logic        clk = 0, rst_n = 0;
  logic        mmio_wr_valid = 0, mmio_rd_valid = 0;
  logic [15:0] mmio_addr = 0;
  logic [8:0]  mmio_tid = 0;
  logic [63:0] mmio_wdata = 0;
  logic        resp_valid, hit, ram_we;
  logic [8:0]  resp_tid;
  logic [63:0] resp_data, ram_wdata, ram_rdata;
  logic [2:0]  ram_waddr, ram_raddr;
  logic [3:0]  count;
  logic [63:0] mem [8];
  int          passed = 0, total = 0;
  vec_t        vq[$];
  mmio_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .resp_valid(resp_valid), .resp_tid(resp_tid), .resp_data(resp_data), .hit(hit),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata), .count(count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask
  task automatic add(input logic wr, input logic rd, input logic [15:0] addr, input logic [63:0] wd,
                     input logic [8:0] tid, input logic ev, input logic [63:0] ed, input logic [3:0] ec);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wd; v.tid = tid;
    v.exp_valid = ev; v.exp_data = ed; v.exp_count = ec;
    vq.push_back(v);
  endtask
  task automatic drive(input logic wr, input logic rd, input logic [15:0] addr, input logic [63:0] wd, input logic [8:0] tid);
    mmio_wr_valid = wr; mmio_rd_valid = rd; mmio_addr = addr; mmio_wdata = wd; mmio_tid = tid;
  endtask
  initial begin
    logic        v_obs [7];
    logic [8:0]  t_obs [7];
    logic [63:0] d_obs [7];
    add(0,1,STAT,0,9'h11,1,64'h10000,0);
    for (int i = 0; i < 8; i++) add(1,0,BASE,64'hA000_0000_0000_0000 + 64'(i),0,0,0,4'(i+1));
    add(0,1,STAT,0,9'h03,1,64'h20008,8);
    add(1,0,BASE,64'hDEAD,0,0,0,8);
    add(0,1,STAT,0,9'h04,1,64'h60008,8);
    for (int i = 0; i < 8; i++) add(0,1,BASE,0,9'(9'h40 + i),1,64'hA000_0000_0000_0000 + 64'(i),4'(7-i));
    add(0,1,BASE,0,9'h05,1,0,0);
    add(0,1,STAT,0,9'h06,1,64'hD0000,0);
    add(1,0,CTRL,64'h2,0,0,0,0);
    add(0,1,STAT,0,9'h07,1,64'h10000,0);
    add(0,1,CTRL,0,9'h08,1,0,0);
    add(0,1,16'h0027,0,9'h09,1,0,0);
    add(0,1,16'h0028,0,9'h0A,0,0,0);
    add(1,0,16'h0030,64'h1,0,0,0,0);
    add(1,0,STAT,64'h1,0,0,0,0);
    for (int i = 0; i < 6; i++) add(1,0,BASE,64'hB0 + 64'(i),0,0,0,4'(i+1));
    for (int i = 0; i < 6; i++) add(0,1,BASE,0,9'(i),1,64'hB0 + 64'(i),4'(5-i));
    for (int i = 0; i < 4; i++) add(1,0,BASE,64'hC0 + 64'(i),0,0,0,4'(i+1));
    for (int i = 0; i < 4; i++) add(0,1,BASE,0,9'(i),1,64'hC0 + 64'(i),4'(3-i));
    add(1,1,BASE,64'h77,9'h1A,1,0,1);
    add(0,1,STAT,0,9'h1B,1,64'h80001,1);
    add(1,1,BASE,64'h88,9'h1C,1,64'h77,1);
    add(1,0,CTRL,64'h3,0,0,0,0);
    add(1,0,BASE,64'h99,0,0,0,1);
    add(1,0,CTRL,64'h1,0,0,0,0);
    add(0,1,STAT,0,9'h1D,1,64'h10000,0);
    add(1,0,BASE,64'hAB,0,0,0,1);
    add(0,1,BASE,0,9'h1E,1,64'hAB,0);
    add(1,0,CTRL,64'h2,0,0,0,0);
    for (int i = 0; i < 3; i++) add(1,0,BASE,64'hE0 + 64'(i),0,0,0,4'(i+1));
    for (int i = 0; i < 2; i++) add(0,1,BASE,0,9'(i),1,64'hE0 + 64'(i),4'(2-i));
    add(0,1,STS,0,9'h1F,1,STATS_EXP,1);
    for (int i = 3; i < 5; i++) add(1,0,BASE,64'hE0 + 64'(i),0,0,0,4'(i-1));
    repeat (3) @(negedge clk);
    chk("reset count", 64'(count), 0);
    chk("reset resp_valid", 64'(resp_valid), 0);
    chk("reset resp_data", resp_data, 0);
    chk("reset ram_we", 64'(ram_we), 0);
    rst_n = 1;
    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].wr, vq[k].rd, vq[k].addr, vq[k].wdata, vq[k].tid);
      @(negedge clk);
      chk($sformatf("v%0d early_valid", k), 64'(resp_valid), 0);
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("v%0d resp_valid", k), 64'(resp_valid), 64'(vq[k].exp_valid));
      if (vq[k].exp_valid) begin
        chk($sformatf("v%0d resp_tid", k), 64'(resp_tid), 64'(vq[k].tid));
        chk($sformatf("v%0d resp_data", k), resp_data, vq[k].exp_data);
      end
      chk($sformatf("v%0d count", k), 64'(count), 64'(vq[k].exp_count));
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      v_obs[i] = resp_valid; t_obs[i] = resp_tid; d_obs[i] = resp_data;
      if (i < 3) drive(0, 1, BASE, 0, 9'(i + 1));
      else drive(0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("b2b valid%0d", i), 64'(v_obs[i]), 64'(i >= 2 && i <= 4));
      if (i >= 2 && i <= 4) begin
        chk($sformatf("b2b tid%0d", i), 64'(t_obs[i]), 64'(i - 1));
        chk($sformatf("b2b data%0d", i), d_obs[i], 64'hE0 + 64'(i));
      end
    end
    chk("b2b count", 64'(count), 0);
    drive(1, 0, BASE, 64'h5, 0);
    @(negedge clk);
    drive(0, 1, STAT, 0, 9'h2);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    chk("pre-reset count", 64'(count), 1);
    #2 rst_n = 0;
    #1;
    chk("async count", 64'(count), 0);
    chk("async resp_valid", 64'(resp_valid), 0);
    @(negedge clk);
    chk("reset flush", 64'(resp_valid), 0);
    rst_n = 1;
    @(negedge clk);
    chk("post-reset valid", 64'(resp_valid), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
